decode_stage_param: RTL and testbench

//  Parametrised IF->ID pipeline stage for the RISC-V core: register file, WB->ID bypass,

---
 rtl/decode_if.sv | 25 ++
 rtl/decode_stage_param.sv | 58 +++++
 tb/tb_decode_stage_param.sv | 139 +++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// decode_if: fetch/writeback inputs and decode-register outputs of the IF->ID stage
interface decode_if #(parameter int XLEN = 32, parameter int PC_W = 14);
  logic            fetch_valid;
  logic [31:0]     inst_f;
  logic [PC_W-1:0] pc_f;
  logic            stall;
  logic            flush;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            dec_valid;
  logic [31:0]     inst_d;
  logic [PC_W-1:0] pc_d;
  logic [XLEN-1:0] rs1_data_d;
  logic [XLEN-1:0] rs2_data_d;
  logic            load_use_hazard;
  modport master (
    output fetch_valid, inst_f, pc_f, stall, flush, wb_we, wb_addr, wb_data,
    input  dec_valid, inst_d, pc_d, rs1_data_d, rs2_data_d, load_use_hazard
  );
  modport slave (
    input  fetch_valid, inst_f, pc_f, stall, flush, wb_we, wb_addr, wb_data,
    output dec_valid, inst_d, pc_d, rs1_data_d, rs2_data_d, load_use_hazard
  );
endinterface

// File: rtl/decode_stage_param.sv
// decode_stage_param: IF->ID register with regfile, WB bypass, stall/flush and load-use detection
module decode_stage_param #(
  parameter int          XLEN     = 32,
  parameter int          PC_W     = 14,
  parameter int          NREGS    = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  d
);
  logic [XLEN-1:0] regs [32];
  logic [4:0]      rs1, rs2, rd_d;
  logic            wb_ok;
  logic [XLEN-1:0] op1, op2;
  function automatic logic live(input logic [4:0] a);
    return a != 5'd0 && int'(a) < NREGS;
  endfunction
  always_comb begin
    rs1   = d.inst_f[19:15];
    rs2   = d.inst_f[24:20];
    rd_d  = d.inst_d[11:7];
    wb_ok = d.wb_we && live(d.wb_addr);
    op1   = (wb_ok && d.wb_addr == rs1) ? d.wb_data : live(rs1) ? regs[rs1] : '0;
    op2   = (wb_ok && d.wb_addr == rs2) ? d.wb_data : live(rs2) ? regs[rs2] : '0;
    d.load_use_hazard = d.dec_valid && d.inst_d[6:0] == 7'b0000011 && rd_d != 5'd0 &&
                        d.fetch_valid && (rd_d == rs1 || rd_d == rs2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      d.dec_valid  <= 1'b0;
      d.inst_d     <= NOP_INST;
      d.pc_d       <= '0;
      d.rs1_data_d <= '0;
      d.rs2_data_d <= '0;
    end else begin
      if (wb_ok) regs[d.wb_addr] <= d.wb_data;
      if (d.flush) begin
        d.dec_valid <= 1'b0;
        d.inst_d    <= NOP_INST;
      end else if (d.stall) begin
        // keep held operands coherent with writebacks landing during the stall
        if (wb_ok && d.wb_addr == d.inst_d[19:15]) d.rs1_data_d <= d.wb_data;
        if (wb_ok && d.wb_addr == d.inst_d[24:20]) d.rs2_data_d <= d.wb_data;
      end else if (d.load_use_hazard) begin
        d.dec_valid <= 1'b0;
        d.inst_d    <= NOP_INST;
      end else begin
        d.dec_valid  <= d.fetch_valid;
        d.inst_d     <= d.fetch_valid ? d.inst_f : NOP_INST;
        d.pc_d       <= d.pc_f;
        d.rs1_data_d <= op1;
        d.rs2_data_d <= op2;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage_param.sv
// tb_decode_stage_param: random + directed stimulus against a behavioural decode-stage model
module tb_decode_stage_param;
  localparam int NR = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, errors = 0;
  decode_if #(.XLEN(32), .PC_W(14)) bus ();
  decode_stage_param #(.XLEN(32), .PC_W(14), .NREGS(NR), .NOP_INST(NOP)) dut (.clk(clk), .rst(rst), .d(bus));
  always #5 clk = ~clk;
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_inst, m_rs1, m_rs2;
  logic [13:0] m_pc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] rf_read(input int a);
    if (a == 0 || a >= NR) return 0;
    return m_rf[a];
  endfunction
  function automatic logic wb_hits(input int a);
    return bus.wb_we && int'(bus.wb_addr) == a && a != 0 && a < NR;
  endfunction
  function automatic logic exp_hazard();
    int rd = int'(m_inst[11:7]);
    return m_valid && m_inst[6:0] == 7'b0000011 && rd != 0 && bus.fetch_valid &&
           (rd == int'(bus.inst_f[19:15]) || rd == int'(bus.inst_f[24:20]));
  endfunction
  task automatic drive(input logic fv, input logic [31:0] inst, input logic [13:0] pc,
                       input logic st, input logic fl, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    bus.fetch_valid = fv; bus.inst_f = inst; bus.pc_f = pc; bus.stall = st; bus.flush = fl;
    bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
  endtask
  // one clock: check combinational hazard, advance the model, check registered outputs
  task automatic cycle();
    logic h;
    logic [31:0] o1, o2;
    #1;
    h = exp_hazard();
    if (!rst) chk("hazard", 32'(bus.load_use_hazard), 32'(h));
    o1 = wb_hits(int'(bus.inst_f[19:15])) ? bus.wb_data : rf_read(int'(bus.inst_f[19:15]));
    o2 = wb_hits(int'(bus.inst_f[24:20])) ? bus.wb_data : rf_read(int'(bus.inst_f[24:20]));
    if (rst) begin
      m_valid = 0; m_inst = NOP; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (bus.flush) begin
        m_valid = 0; m_inst = NOP;
      end else if (bus.stall) begin
        if (wb_hits(int'(m_inst[19:15]))) m_rs1 = bus.wb_data;
        if (wb_hits(int'(m_inst[24:20]))) m_rs2 = bus.wb_data;
      end else if (h) begin
        m_valid = 0; m_inst = NOP;
      end else begin
        m_valid = bus.fetch_valid;
        m_inst = bus.fetch_valid ? bus.inst_f : NOP;
        m_pc = bus.pc_f; m_rs1 = o1; m_rs2 = o2;
      end
      if (wb_hits(int'(bus.wb_addr))) m_rf[bus.wb_addr] = bus.wb_data;
    end
    @(posedge clk);
    #1;
    chk("dec_valid", 32'(bus.dec_valid), 32'(m_valid));
    chk("inst_d", bus.inst_d, m_inst);
    chk("pc_d", 32'(bus.pc_d), 32'(m_pc));
    chk("rs1_data_d", bus.rs1_data_d, m_rs1);
    chk("rs2_data_d", bus.rs2_data_d, m_rs2);
  endtask
  initial begin
    logic [31:0] ri;
    rst = 1;
    drive(0, NOP, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("reset_inst", bus.inst_d, 32'h0000_0013);
    chk("reset_valid", 32'(bus.dec_valid), 32'd0);
    rst = 0;
    drive(0, NOP, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    cycle();
    drive(1, 32'h0002_8013, 14'h10, 0, 0, 0, 0, 0);
    cycle();
    chk("t1_rs1_x5", bus.rs1_data_d, 32'hDEADBEEF);
    drive(1, 32'h0070_0033, 14'h14, 0, 0, 1, 5'd7, 32'h1234);
    cycle();
    chk("t2_bypass_x7", bus.rs2_data_d, 32'h1234);
    drive(0, NOP, 0, 0, 0, 1, 5'd0, 32'hFF);
    cycle();
    drive(1, 32'h0000_0033, 14'h18, 0, 0, 0, 0, 0);
    cycle();
    chk("t2_x0_zero", bus.rs1_data_d, 32'd0);
    drive(1, 32'h0000_A183, 14'h1C, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 32'h0011_8233, 14'h20, 0, 0, 0, 0, 0);
    #1 chk("t3_hazard_set", 32'(bus.load_use_hazard), 32'd1);
    cycle();
    chk("t3_bubble_inst", bus.inst_d, NOP);
    chk("t3_bubble_valid", 32'(bus.dec_valid), 32'd0);
    drive(1, 32'h0004_8093, 14'h24, 0, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0000_0033, 14'h28, 1, 0, i == 1, 5'd9, 32'h55);
      cycle();
    end
    chk("t4_stall_inst", bus.inst_d, 32'h0004_8093);
    chk("t4_stall_rs1", bus.rs1_data_d, 32'h55);
    drive(1, 32'h0000_0033, 14'h2C, 1, 1, 0, 0, 0);
    cycle();
    chk("t5_flush_valid", 32'(bus.dec_valid), 32'd0);
    chk("t5_flush_inst", bus.inst_d, 32'h0000_0013);
    drive(0, NOP, 0, 0, 0, 1, 5'd20, 32'h1);
    cycle();
    drive(1, 32'h000A_0013, 14'h30, 0, 0, 0, 0, 0);
    cycle();
    chk("t6_x20_zero", bus.rs1_data_d, 32'd0);
    drive(0, 32'h0011_8233, 14'h34, 0, 0, 0, 0, 0);
    cycle();
    chk("t6_fv0_valid", 32'(bus.dec_valid), 32'd0);
    chk("t6_fv0_inst", bus.inst_d, NOP);
    for (int n = 0; n < 3000; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 2) == 0) ri[6:0] = 7'b0000011;
      ri[19:15] = 5'($urandom_range(0, 19));
      ri[24:20] = 5'($urandom_range(0, 19));
      ri[11:7]  = 5'($urandom_range(0, 19));
      rst = $urandom_range(0, 199) == 0;
      drive($urandom_range(0, 9) < 8, ri, 14'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), $urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
